// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write sequencer.
// Holds the register-file geometry, the sequencer FSM state encoding and
// the packed layout of one queued write request.
package regfile_pkg;

  localparam int RF_ADDR_W = 3;
  localparam int RF_DATA_W = 8;
  localparam int RF_NREGS  = 8;

  // One request as stored in the FIFO: {addr, data, verify}
  localparam int REQ_W = RF_ADDR_W + RF_DATA_W + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    CLEAR = 3'd4
  } state_e;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
    logic                 verify;
  } req_t;

endpackage

// File: rtl/reg_write_sequencer_if.sv
// Write-request handshake between an upstream producer and the sequencer.
//   REQ_VALID  : producer has a request on REQ_ADDR/REQ_DATA/REQ_VERIFY
//   REQ_READY  : sequencer can take it this cycle
//   REQ_ADDR   : target register number
//   REQ_DATA   : value to write
//   REQ_VERIFY : read the register back after writing and compare
// master = producer side, slave = sequencer side.
interface reg_write_sequencer_if;
  import regfile_pkg::*;

  logic                 REQ_VALID;
  logic                 REQ_READY;
  logic [RF_ADDR_W-1:0] REQ_ADDR;
  logic [RF_DATA_W-1:0] REQ_DATA;
  logic                 REQ_VERIFY;

  modport master (
    output REQ_VALID, REQ_ADDR, REQ_DATA, REQ_VERIFY,
    input  REQ_READY
  );

  modport slave (
    input  REQ_VALID, REQ_ADDR, REQ_DATA, REQ_VERIFY,
    output REQ_READY
  );

endinterface

// File: rtl/reg_write_sequencer_req_fifo.sv
// Synchronous request FIFO with full/empty flags.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   i_push, i_data : write one entry (ignored when full)
//   i_pop          : drop the head entry (ignored when empty)
//   o_data         : head entry, valid whenever o_empty=0
//   o_full/o_empty : occupancy flags
module req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/reg_write_sequencer.sv
// Register-file write initiator.
// Queues (address, data, verify) requests, issues them one per cycle onto
// the register file's WRITE/INADDRESS/IN inputs, optionally reads each one
// back through OUT1 and flags the first mismatch, and can zero all
// registers with a bulk-clear sequence.
//   CLK, RESET         : clock, asynchronous active-low reset
//   req (slave)        : REQ_VALID/READY/ADDR/DATA/VERIFY request handshake
//   CLEAR_START        : one-cycle pulse, zero registers 0..7
//   WRITE/INADDRESS/IN : register-file write port (registered)
//   OUT1ADDRESS, OUT1  : register-file read port used for verify
//   BUSY               : work queued or in progress
//   ERR, ERR_ADDR      : sticky verify mismatch and its register number
//   WR_COUNT           : writes issued, modulo 256
module reg_write_sequencer
  import regfile_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int VERIFY_WAIT = 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  reg_write_sequencer_if.slave req,
  input  logic                 CLEAR_START,
  output logic                 WRITE,
  output logic [RF_ADDR_W-1:0] INADDRESS,
  output logic [RF_DATA_W-1:0] IN,
  output logic [RF_ADDR_W-1:0] OUT1ADDRESS,
  input  logic [RF_DATA_W-1:0] OUT1,
  output logic                 BUSY,
  output logic                 ERR,
  output logic [RF_ADDR_W-1:0] ERR_ADDR,
  output logic [7:0]           WR_COUNT
);

  localparam int WAIT_W = (VERIFY_WAIT > 1) ? $clog2(VERIFY_WAIT) : 1;
  localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(VERIFY_WAIT - 1);
  localparam logic [RF_ADDR_W-1:0] CLR_LAST  = RF_ADDR_W'(RF_NREGS - 1);

  state_e               r_state, w_state_n;
  logic                 r_write, w_write_n;
  logic [RF_ADDR_W-1:0] r_inaddr, w_inaddr_n;
  logic [RF_DATA_W-1:0] r_in, w_in_n;
  logic [RF_ADDR_W-1:0] r_rdaddr, w_rdaddr_n;
  logic                 r_verify, w_verify_n;
  logic [WAIT_W-1:0]    r_wait, w_wait_n;
  logic [RF_ADDR_W-1:0] r_clr, w_clr_n;
  logic                 r_err, w_err_n;
  logic [RF_ADDR_W-1:0] r_err_addr, w_err_addr_n;
  logic [7:0]           r_wr_count, w_wr_count_n;

  logic                 w_ready;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_load;
  logic                 w_full;
  logic                 w_empty;
  logic [REQ_W-1:0]     w_fifo_rdata;
  req_t                 w_head;

  // READY is forced low while in reset so nothing is accepted then.
  assign w_ready       = RESET && !w_full && (r_state != CLEAR);
  assign req.REQ_READY = w_ready;
  assign w_push        = req.REQ_VALID && w_ready;
  assign w_head        = w_fifo_rdata;

  req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REQ_W)
  ) u_req_fifo (
    .i_clk   (CLK),
    .i_rst_n (RESET),
    .i_push  (w_push),
    .i_data  ({req.REQ_ADDR, req.REQ_DATA, req.REQ_VERIFY}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_n    = r_state;
    w_write_n    = 1'b0;
    w_inaddr_n   = r_inaddr;
    w_in_n       = r_in;
    w_rdaddr_n   = r_rdaddr;
    w_verify_n   = r_verify;
    w_wait_n     = r_wait;
    w_clr_n      = r_clr;
    w_err_n      = r_err;
    w_err_addr_n = r_err_addr;
    w_wr_count_n = r_wr_count;
    w_load       = 1'b0;
    w_pop        = 1'b0;

    case (r_state)
      IDLE: begin
        // Clear wins over queued work; the queue is left intact.
        if (CLEAR_START) begin
          w_state_n    = CLEAR;
          w_write_n    = 1'b1;
          w_inaddr_n   = '0;
          w_in_n       = '0;
          w_clr_n      = '0;
          w_wr_count_n = r_wr_count + 8'd1;
        end else if (!w_empty) begin
          w_state_n = ISSUE;
          w_load    = 1'b1;
        end
      end
      ISSUE: begin
        // A verify must complete before the next write goes out.
        if (r_verify) begin
          w_state_n = WAIT;
          w_wait_n  = '0;
        end else if (!w_empty) begin
          w_load = 1'b1;
        end else begin
          w_state_n = IDLE;
        end
      end
      WAIT: begin
        if (r_wait == WAIT_LAST) w_state_n = CHECK;
        else                     w_wait_n  = r_wait + 1'b1;
      end
      CHECK: begin
        // r_in still holds the data that was written to r_rdaddr.
        if ((OUT1 != r_in) && !r_err) begin
          w_err_n      = 1'b1;
          w_err_addr_n = r_rdaddr;
        end
        w_state_n = IDLE;
      end
      CLEAR: begin
        if (r_clr == CLR_LAST) begin
          w_state_n = IDLE;
        end else begin
          w_write_n    = 1'b1;
          w_clr_n      = r_clr + 1'b1;
          w_inaddr_n   = r_clr + 1'b1;
          w_wr_count_n = r_wr_count + 8'd1;
        end
      end
      default: w_state_n = IDLE;
    endcase

    if (w_load) begin
      w_pop        = 1'b1;
      w_write_n    = 1'b1;
      w_inaddr_n   = w_head.addr;
      w_in_n       = w_head.data;
      w_rdaddr_n   = w_head.addr;
      w_verify_n   = w_head.verify;
      w_wr_count_n = r_wr_count + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= IDLE;
      r_write    <= 1'b0;
      r_inaddr   <= '0;
      r_in       <= '0;
      r_rdaddr   <= '0;
      r_verify   <= 1'b0;
      r_wait     <= '0;
      r_clr      <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
      r_wr_count <= '0;
    end else begin
      r_state    <= w_state_n;
      r_write    <= w_write_n;
      r_inaddr   <= w_inaddr_n;
      r_in       <= w_in_n;
      r_rdaddr   <= w_rdaddr_n;
      r_verify   <= w_verify_n;
      r_wait     <= w_wait_n;
      r_clr      <= w_clr_n;
      r_err      <= w_err_n;
      r_err_addr <= w_err_addr_n;
      r_wr_count <= w_wr_count_n;
    end
  end

  assign WRITE       = r_write;
  assign INADDRESS   = r_inaddr;
  assign IN          = r_in;
  assign OUT1ADDRESS = r_rdaddr;
  assign ERR         = r_err;
  assign ERR_ADDR    = r_err_addr;
  assign WR_COUNT    = r_wr_count;
  assign BUSY        = !w_empty || (r_state != IDLE);

endmodule

// File: tb/tb_reg_write_sequencer.sv
// Bench for reg_write_sequencer with a behavioural register file attached.
module tb_reg_write_sequencer;
  import regfile_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       CLEAR_START = 1'b0;
  logic       WRITE;
  logic [2:0] INADDRESS;
  logic [7:0] IN;
  logic [2:0] OUT1ADDRESS;
  logic [7:0] OUT1;
  logic       BUSY;
  logic       ERR;
  logic [2:0] ERR_ADDR;
  logic [7:0] WR_COUNT;
  logic       force0 = 1'b0;

  reg_write_sequencer_if rif ();

  always #5 CLK = ~CLK;

  reg_write_sequencer #(.DEPTH(4), .VERIFY_WAIT(1)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .req         (rif),
    .CLEAR_START (CLEAR_START),
    .WRITE       (WRITE),
    .INADDRESS   (INADDRESS),
    .IN          (IN),
    .OUT1ADDRESS (OUT1ADDRESS),
    .OUT1        (OUT1),
    .BUSY        (BUSY),
    .ERR         (ERR),
    .ERR_ADDR    (ERR_ADDR),
    .WR_COUNT    (WR_COUNT)
  );

  // Register file: writes on posedge, combinational read. force0 models a
  // corrupted read-back.
  typedef struct packed { logic [2:0] a; logic [7:0] d; } wr_t;
  logic [7:0] rf [8];
  wr_t obs_q [$];
  int  obs_cyc [$];
  int  cyc;

  assign OUT1 = force0 ? 8'h00 : rf[OUT1ADDRESS];

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (WRITE === 1'b1) begin
      rf[INADDRESS] <= IN;
      obs_q.push_back('{a: INADDRESS, d: IN});
      obs_cyc.push_back(cyc);
    end
  end

  // Reference model: expected write stream, write count and register image.
  wr_t        exp_q [$];
  int         model_cnt = 0;
  logic [7:0] mdl_rf [8];
  int         obs_base = 0;
  int         total = 0;
  int         bad = 0;
  int         stall_cnt = 0;

  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
    logic       v;
    logic       f;
    logic       e;
    logic [2:0] ea;
    logic [7:0] cnt;
  } vec_t;
  vec_t vt [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic exp_write(input logic [2:0] a, input logic [7:0] d);
    exp_q.push_back('{a: a, d: d});
    model_cnt = (model_cnt + 1) % 256;
    mdl_rf[a] = d;
  endtask

  task automatic push(input logic [2:0] a, input logic [7:0] d, input logic v);
    int guard = 0;
    rif.REQ_VALID  = 1'b1;
    rif.REQ_ADDR   = a;
    rif.REQ_DATA   = d;
    rif.REQ_VERIFY = v;
    while (rif.REQ_READY !== 1'b1 && guard < 200) begin
      tick();
      guard++;
      stall_cnt++;
    end
    if (guard >= 200) chk("push_timeout", 0, 1);
    tick();
    rif.REQ_VALID = 1'b0;
    exp_write(a, d);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (BUSY !== 1'b0 && guard < 2000) begin
      tick();
      guard++;
    end
    if (guard >= 2000) chk("idle_timeout", 0, 1);
  endtask

  task automatic check_writes();
    int n;
    n = obs_q.size() - obs_base;
    chk("n_writes", n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      chk("wr_addr", obs_q[obs_base+i].a, exp_q[i].a);
      chk("wr_data", obs_q[obs_base+i].d, exp_q[i].d);
    end
    chk("wr_count", WR_COUNT, model_cnt);
    obs_base = obs_q.size();
    exp_q.delete();
  endtask

  task automatic check_rf();
    for (int i = 0; i < 8; i++) chk("rf_contents", rf[i], mdl_rf[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int cnt0;
    rif.REQ_VALID  = 1'b0;
    rif.REQ_ADDR   = '0;
    rif.REQ_DATA   = '0;
    rif.REQ_VERIFY = 1'b0;

    vt[0] = '{3'd2, 8'h3C, 1'b1, 1'b0, 1'b0, 3'd0, 8'd2};
    vt[1] = '{3'd6, 8'h55, 1'b1, 1'b1, 1'b1, 3'd6, 8'd3};
    vt[2] = '{3'd1, 8'h77, 1'b1, 1'b0, 1'b1, 3'd6, 8'd4};
    vt[3] = '{3'd5, 8'h12, 1'b0, 1'b0, 1'b1, 3'd6, 8'd5};
    vt[4] = '{3'd4, 8'h00, 1'b1, 1'b0, 1'b1, 3'd6, 8'd6};

    // Reset state
    #12;
    chk("rst_ready", rif.REQ_READY, 0);
    chk("rst_write", WRITE, 0);
    chk("rst_inaddr", INADDRESS, 0);
    chk("rst_in", IN, 0);
    chk("rst_out1addr", OUT1ADDRESS, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_err", ERR, 0);
    chk("rst_err_addr", ERR_ADDR, 0);
    chk("rst_wr_count", WR_COUNT, 0);
    @(negedge CLK);
    RESET = 1'b1;
    tick();
    chk("ready_after_rst", rif.REQ_READY, 1);

    // Single write
    push(3'd3, 8'hA5, 1'b0);
    wait_idle();
    check_writes();
    chk("single_count", WR_COUNT, 1);
    chk("single_rf3", rf[3], 8'hA5);

    // Verify pass / fail table
    for (int i = 0; i < 5; i++) begin
      force0 = vt[i].f;
      push(vt[i].a, vt[i].d, vt[i].v);
      wait_idle();
      force0 = 1'b0;
      chk("vec_err", ERR, vt[i].e);
      chk("vec_err_addr", ERR_ADDR, vt[i].ea);
      chk("vec_count", WR_COUNT, vt[i].cnt);
      chk("vec_rf", rf[vt[i].a], vt[i].d);
      check_writes();
    end

    // Backpressure: verify entries drain slowly so the FIFO fills
    stall_cnt = 0;
    for (int i = 0; i < 6; i++) push(3'(i), 8'hA0 + 8'(i), 1'b1);
    chk("bp_stall_seen", (stall_cnt > 0), 1);
    wait_idle();
    check_writes();
    chk("bp_err_sticky", ERR, 1);
    chk("bp_err_addr", ERR_ADDR, 6);

    // Bulk clear with two requests queued
    for (int i = 0; i < 8; i++) push(3'(i), 8'h11 * 8'(i + 1), 1'b0);
    wait_idle();
    check_writes();
    cnt0 = model_cnt;
    rif.REQ_VALID = 1'b1; rif.REQ_ADDR = 3'd2; rif.REQ_DATA = 8'hB2; rif.REQ_VERIFY = 1'b0;
    tick();
    rif.REQ_ADDR = 3'd7; rif.REQ_DATA = 8'hC7;
    CLEAR_START = 1'b1;
    chk("clr_ready_before", rif.REQ_READY, 1);
    tick();
    CLEAR_START = 1'b0;
    rif.REQ_VALID = 1'b0;
    for (int i = 0; i < 8; i++) exp_write(3'(i), 8'h00);
    exp_write(3'd2, 8'hB2);
    exp_write(3'd7, 8'hC7);
    chk("clr_ready0", rif.REQ_READY, 0);
    chk("clr_write", WRITE, 1);
    chk("clr_first_addr", INADDRESS, 0);
    for (int k = 0; k < 7; k++) begin
      CLEAR_START = (k == 2);
      tick();
      chk("clr_ready_hold", rif.REQ_READY, 0);
    end
    CLEAR_START = 1'b0;
    wait_idle();
    if (obs_q.size() - obs_base >= 8)
      chk("clr_consecutive", obs_cyc[obs_base+7] - obs_cyc[obs_base], 7);
    else
      chk("clr_consecutive", obs_q.size() - obs_base, 8);
    check_writes();
    chk("clr_count_plus10", WR_COUNT, (cnt0 + 10) % 256);
    check_rf();

    // Randomized requests against the model
    for (int n = 0; n < 40; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
      push(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    wait_idle();
    check_writes();
    check_rf();
    chk("rand_err_sticky", ERR, 1);

    // WR_COUNT wrap after reset
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    tick();
    model_cnt = 0;
    obs_base = obs_q.size();
    exp_q.delete();
    chk("wrap_err_cleared", ERR, 0);
    for (int i = 0; i < 255; i++) push(3'(i % 8), 8'(i), 1'b0);
    wait_idle();
    chk("wrap_255", WR_COUNT, 255);
    push(3'd0, 8'hEE, 1'b0);
    wait_idle();
    chk("wrap_0", WR_COUNT, 0);
    check_writes();

    // Async reset in the middle of a clear
    force0 = 1'b1;
    push(3'd6, 8'h99, 1'b1);
    wait_idle();
    force0 = 1'b0;
    chk("pre_rst_err", ERR, 1);
    CLEAR_START = 1'b1;
    tick();
    CLEAR_START = 1'b0;
    guard = 0;
    while (!(WRITE === 1'b1 && INADDRESS == 3'd4) && guard < 20) begin
      tick();
      guard++;
    end
    chk("clr_reached_4", INADDRESS, 4);
    #2;
    RESET = 1'b0;
    #1;
    chk("arst_write", WRITE, 0);
    chk("arst_busy", BUSY, 0);
    chk("arst_count", WR_COUNT, 0);
    chk("arst_err", ERR, 0);
    chk("arst_inaddr", INADDRESS, 0);
    chk("arst_ready", rif.REQ_READY, 0);
    @(negedge CLK);
    RESET = 1'b1;
    tick();
    chk("arst_ready_after", rif.REQ_READY, 1);
    chk("arst_write_after", WRITE, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_write_sequencer.md
Name: reg_write_sequencer

Overview:
- Initiator for the register-file write port: accepts (address, data) write requests over a valid/ready handshake and buffers them in a small FIFO.
- Drains the FIFO one write per issue slot onto the register file's WRITE/INADDRESS/IN inputs.
- Optionally reads each written register back through the OUT1 read port and compares it.
- Also runs a bulk-clear sequence that zeroes all 8 registers without asserting the register file's RESET.

Parameters:
- DEPTH, 4, request FIFO entries; power of two, 2..16.
- VERIFY_WAIT, 1, idle cycles between write issue and read-back sample; ≥1, covers the register file's write delay and read delay.

Ports:
- CLK  input  1  system clock; all state changes on posedge.
- RESET  input  1  asynchronous, active-low reset (0 = reset).
- REQ_VALID  input  1  upstream write request valid.
- REQ_READY  output  1  FIFO can accept (not full, not clearing).
- REQ_ADDR  input  3  target register number.
- REQ_DATA  input  8  data to write.
- REQ_VERIFY  input  1  read back and compare after this write.
- CLEAR_START  input  1  single-cycle pulse: zero registers 0..7.
- WRITE  output  1  register-file write enable.
- INADDRESS  output  3  register-file write address.
- IN  output  8  register-file write data.
- OUT1ADDRESS  output  3  register-file read address for verify.
- OUT1  input  8  register-file read data.
- BUSY  output  1  FIFO non-empty or FSM not IDLE.
- ERR  output  1  sticky verify mismatch.
- ERR_ADDR  output  3  address of the first mismatch.
- WR_COUNT  output  8  writes issued, wraps at 255→0.

Behaviour:
- Reset (RESET=0, async): FIFO empty, FSM=IDLE. WRITE=0, INADDRESS=0, IN=0, OUT1ADDRESS=0, ERR=0, ERR_ADDR=0, WR_COUNT=0. REQ_READY=0 while RESET=0; 1 after release.
- Accept: on a posedge where REQ_VALID&&REQ_READY, push {ADDR,DATA,VERIFY}. REQ_READY=0 when full or FSM∈{CLEAR}.
- Simultaneous push and pop while full is not allowed, because READY is already 0. Push and pop in the same cycle at any other occupancy keeps the count unchanged.
- FSM states:
  - IDLE:
    - If CLEAR_START=1, go to CLEAR. CLEAR has priority over a non-empty FIFO; the FIFO is held and not flushed.
    - Else if the FIFO is non-empty, pop and go to ISSUE.
  - ISSUE (1 cycle): WRITE=1, INADDRESS/IN = popped entry. WR_COUNT+1. OUT1ADDRESS=addr.
    - If VERIFY=1, go to WAIT.
    - Else return to IDLE, or pop the next entry and stay in ISSUE. Back-to-back writes sustain 1 write/cycle.
  - WAIT: WRITE=0, OUT1ADDRESS held. Count VERIFY_WAIT cycles, then go to CHECK.
  - CHECK (1 cycle): if OUT1≠expected data and ERR=0, set ERR=1 and ERR_ADDR=addr. Go to IDLE. ERR stays set until reset.
  - CLEAR: 8 cycles, WRITE=1, INADDRESS=0,1..7, IN=0. WR_COUNT+8 (wrapping). Then go to IDLE. CLEAR_START while in CLEAR is ignored.
- Outputs WRITE, INADDRESS, IN and OUT1ADDRESS are registered; no combinational path from REQ_* to the register-file ports.
- WRITE=0 in every state except ISSUE and CLEAR.
- Reset mid-operation: an in-flight write is dropped, WRITE=0 immediately, FIFO contents are lost.
- Writes are issued in FIFO order. A verify read-back always follows its own write before the next write is issued.

Decomposition:
- Shared package `regfile_pkg`:
  - RF_ADDR_W=3, RF_DATA_W=8, RF_NREGS=8.
  - FSM state encoding constants: IDLE, ISSUE, WAIT, CHECK, CLEAR.
- One natural sub-module: `req_fifo`, a synchronous FIFO, width 12 (3+8+1), depth DEPTH, with full/empty flags and async active-low reset.

Test Plan:
- Single write: push addr=3, data=8'hA5, verify=0 → one cycle of WRITE=1, INADDRESS=3, IN=A5. WR_COUNT=1. Register 3 reads A5.
- Backpressure: push 5 requests with DEPTH=4 and the FSM stalled by a verify entry → REQ_READY=0 after 4 accepted. The 5th is accepted once the first pops. All 5 are written in order.
- Verify pass/fail: write addr=2, 8'h3C, verify=1 against the real register file → ERR=0. Force OUT1 to 8'h00 during CHECK for addr=6 → ERR=1, ERR_ADDR=6, sticky through later passes.
- Bulk clear: preload regs with 8'h11..8'h88, pulse CLEAR_START with 2 requests queued → 8 consecutive writes of 0 to addresses 0..7. REQ_READY=0 during the sequence. Queued requests are issued afterwards. WR_COUNT=+10.
- WR_COUNT wrap: issue 256 writes → WR_COUNT=0.
- Async reset mid-CLEAR (RESET=0 at address 4) → WRITE=0 without waiting for a clock edge. BUSY=0, counters and ERR cleared. REQ_READY=1 after release.
